// File: rtl/serial_demux_deserializer_if.sv
// Handshake bundle between the serial load port, the deserializer and the
// parallel word consumer. The slave modport is the deserializer's view.
interface serial_demux_deserializer_if #(
    parameter int WIDTH = 64
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_bit;
    logic             frame_st;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic [CNT_W-1:0] bit_cnt;

    modport slave (
        input  in_valid,
        input  in_bit,
        input  frame_st,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_word,
        output bit_cnt
    );

    modport master (
        output in_valid,
        output in_bit,
        output frame_st,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_word,
        input  bit_cnt
    );
endinterface

// File: rtl/serial_demux_deserializer.sv
// 1-to-WIDTH serial deserializer. A bit-index counter feeds a one-hot decoder
// that steers each accepted serial bit (LSB first) into its slot of a shadow
// word. When the top slot is written the full word is published on out_word
// with a valid/ready handshake. A handoff and the first bit of the next word
// may share a cycle, so words can stream back to back.
module serial_demux_deserializer #(
    parameter int WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    serial_demux_deserializer_if.slave    s_if
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] HOT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_t;

    // Architectural state
    state_t           r_state;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_out_word;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_bit_cnt;

    // Next-state values
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic [WIDTH-1:0] w_out_word_nxt;
    logic             w_out_valid_nxt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;

    // Handshake and steering terms
    logic             w_handoff;
    logic             w_in_ready;
    logic             w_accept;
    logic [CNT_W-1:0] w_idx;
    logic             w_last;
    logic             w_complete;
    logic [WIDTH-1:0] w_onehot;

    // A frame start forces the bit into slot 0, abandoning any partial word.
    assign w_handoff  = r_out_valid & s_if.out_ready;
    assign w_in_ready = (r_state == ST_COLLECT) | w_handoff;
    assign w_accept   = s_if.in_valid & w_in_ready;
    assign w_idx      = s_if.frame_st ? CNT_ZERO : r_bit_cnt;
    assign w_last     = (w_idx == LAST_IDX);
    assign w_complete = w_accept & w_last;
    assign w_onehot   = HOT_ONE << w_idx;

    // Demux datapath: write exactly the decoded slot and advance the bit index.
    always_comb begin
        w_shadow_nxt  = r_shadow;
        w_bit_cnt_nxt = r_bit_cnt;
        if (w_accept) begin
            w_shadow_nxt = (r_shadow & ~w_onehot) | (w_onehot & {WIDTH{s_if.in_bit}});
            if (w_last) begin
                w_bit_cnt_nxt = CNT_ZERO;
            end else begin
                w_bit_cnt_nxt = w_idx + CNT_ONE;
            end
        end else begin
            w_shadow_nxt  = r_shadow;
            w_bit_cnt_nxt = r_bit_cnt;
        end
    end

    // Control FSM: publish a completed word, release it on handoff.
    always_comb begin
        w_state_nxt     = r_state;
        w_out_word_nxt  = r_out_word;
        w_out_valid_nxt = r_out_valid;
        case (r_state)
            ST_COLLECT: begin
                if (w_complete) begin
                    w_out_word_nxt  = {s_if.in_bit, r_shadow[WIDTH-2:0]};
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_FULL;
                end else begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_COLLECT;
                end
            end
            ST_FULL: begin
                if (w_handoff) begin
                    if (w_complete) begin
                        w_out_word_nxt  = {s_if.in_bit, r_shadow[WIDTH-2:0]};
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = ST_FULL;
                    end else begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = ST_COLLECT;
                    end
                end else begin
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_FULL;
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
                w_state_nxt     = ST_COLLECT;
            end
        endcase
    end

    // State register with synchronous active-high reset that drops partial words.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_COLLECT;
            r_shadow    <= {WIDTH{1'b0}};
            r_out_word  <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_bit_cnt   <= CNT_ZERO;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            r_out_word  <= w_out_word_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
        end
    end

    assign s_if.in_ready  = w_in_ready;
    assign s_if.out_valid = r_out_valid;
    assign s_if.out_word  = r_out_word;
    assign s_if.bit_cnt   = r_bit_cnt;
endmodule

// File: tb/tb_serial_demux_deserializer.sv
// Directed bench for serial_demux_deserializer: an 8-bit instance for the
// handshake and framing cases and a 64-bit instance for the wide word.
// Expected words go into per-instance queues when a word is sent and are
// popped when the DUT performs a handoff.
module tb_serial_demux_deserializer;
    logic clk;
    logic reset;

    int total_checks  = 0;
    int passed_checks = 0;

    logic [63:0] q8[$];
    logic [63:0] q64[$];

    serial_demux_deserializer_if #(.WIDTH(8))  if8  ();
    serial_demux_deserializer_if #(.WIDTH(64)) if64 ();

    serial_demux_deserializer #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .s_if  (if8)
    );

    serial_demux_deserializer #(.WIDTH(64)) dut64 (
        .clk   (clk),
        .reset (reset),
        .s_if  (if64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one bit and hold it until the DUT accepts it (bounded).
    task automatic send_bit(input bit sel64, input logic b, input logic fs);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        if (sel64) begin
            if64.in_valid = 1'b1; if64.in_bit = b; if64.frame_st = fs;
        end else begin
            if8.in_valid = 1'b1;  if8.in_bit = b;  if8.frame_st = fs;
        end
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = sel64 ? if64.in_ready : if8.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("bit_accepted", 64'(acc), 64'd1);
        if (sel64) begin
            if64.in_valid = 1'b0; if64.frame_st = 1'b0;
        end else begin
            if8.in_valid = 1'b0;  if8.frame_st = 1'b0;
        end
    endtask

    task automatic send_bits8(input logic [7:0] w, input int first, input int count, input logic fs);
        for (int i = first; i < first + count; i++) begin
            send_bit(1'b0, w[i], (i == first) ? fs : 1'b0);
        end
    endtask

    // Scoreboard side: every handoff must match the oldest expected word.
    always @(negedge clk) begin
        if (if8.out_valid === 1'b1 && if8.out_ready === 1'b1) begin
            check("w8_word_expected", 64'(q8.size() != 0), 64'd1);
            if (q8.size() != 0) check("w8_handoff_word", 64'(if8.out_word), q8.pop_front());
        end
        if (if64.out_valid === 1'b1 && if64.out_ready === 1'b1) begin
            check("w64_word_expected", 64'(q64.size() != 0), 64'd1);
            if (q64.size() != 0) check("w64_handoff_word", if64.out_word, q64.pop_front());
        end
    end

    initial begin
        logic [63:0] big;
        big = 64'hDEADBEEF_01234567;

        reset = 1'b1;
        if8.in_valid = 1'b0;  if8.in_bit = 1'b0;  if8.frame_st = 1'b0;  if8.out_ready = 1'b0;
        if64.in_valid = 1'b0; if64.in_bit = 1'b0; if64.frame_st = 1'b0; if64.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // 1: reset state after idle cycles
        repeat (3) tick();
        check("rst_out_valid", 64'(if8.out_valid), 64'd0);
        check("rst_out_word",  64'(if8.out_word),  64'h00);
        check("rst_bit_cnt",   64'(if8.bit_cnt),   64'd0);
        check("rst_in_ready",  64'(if8.in_ready),  64'd1);

        // 2: 0xA5 with consumer ready, valid for exactly one cycle
        if8.out_ready = 1'b1;
        q8.push_back(64'hA5);
        send_bits8(8'hA5, 0, 7, 1'b0);
        check("a5_not_yet_valid", 64'(if8.out_valid), 64'd0);
        check("a5_cnt7",          64'(if8.bit_cnt),   64'd7);
        send_bits8(8'hA5, 7, 1, 1'b0);
        check("a5_valid",   64'(if8.out_valid), 64'd1);
        check("a5_word",    64'(if8.out_word),  64'hA5);
        check("a5_cnt_wrap", 64'(if8.bit_cnt),  64'd0);
        tick();
        check("a5_valid_drop", 64'(if8.out_valid), 64'd0);

        // 3: 0x3C held while consumer stalls, further bits refused
        if8.out_ready = 1'b0;
        q8.push_back(64'h3C);
        send_bits8(8'h3C, 0, 8, 1'b0);
        if8.in_valid = 1'b1;
        if8.in_bit   = 1'b1;
        #1;
        check("stall_in_ready", 64'(if8.in_ready), 64'd0);
        repeat (4) tick();
        if8.in_valid = 1'b0;
        check("stall_word",  64'(if8.out_word),  64'h3C);
        check("stall_valid", 64'(if8.out_valid), 64'd1);
        check("stall_cnt",   64'(if8.bit_cnt),   64'd0);
        if8.out_ready = 1'b1;
        tick();
        check("stall_release", 64'(if8.out_valid), 64'd0);
        q8.push_back(64'h96);
        send_bits8(8'h96, 0, 8, 1'b0);
        check("after_stall_word", 64'(if8.out_word), 64'h96);
        tick();

        // 4: 0x0F then 0xF0 with handoff on bit 0 of the second word
        if8.out_ready = 1'b0;
        q8.push_back(64'h0F);
        q8.push_back(64'hF0);
        send_bits8(8'h0F, 0, 8, 1'b0);
        check("b2b_first_held", 64'(if8.out_word), 64'h0F);
        if8.out_ready = 1'b1;
        send_bits8(8'hF0, 0, 1, 1'b0);
        check("b2b_valid_drop", 64'(if8.out_valid), 64'd0);
        check("b2b_cnt1",       64'(if8.bit_cnt),   64'd1);
        send_bits8(8'hF0, 1, 7, 1'b0);
        check("b2b_second_valid", 64'(if8.out_valid), 64'd1);
        tick();

        // 5: abandoned partial 0x07, resynchronised 0x81
        q8.push_back(64'h81);
        send_bits8(8'h07, 0, 3, 1'b0);
        check("partial_cnt3", 64'(if8.bit_cnt), 64'd3);
        send_bits8(8'h81, 0, 8, 1'b1);
        check("resync_word", 64'(if8.out_word), 64'h81);
        tick();

        // 6: reset mid-word, then a clean 0x55
        send_bits8(8'h55, 0, 6, 1'b0);
        check("pre_reset_cnt", 64'(if8.bit_cnt), 64'd6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_cnt",   64'(if8.bit_cnt),   64'd0);
        check("mid_rst_valid", 64'(if8.out_valid), 64'd0);
        check("mid_rst_word",  64'(if8.out_word),  64'h00);
        q8.push_back(64'h55);
        send_bits8(8'h55, 0, 7, 1'b0);
        check("post_rst_7bits", 64'(if8.out_valid), 64'd0);
        send_bits8(8'h55, 7, 1, 1'b0);
        check("post_rst_valid", 64'(if8.out_valid), 64'd1);
        check("post_rst_word",  64'(if8.out_word),  64'h55);
        tick();

        // 7: 64-bit word
        if64.out_ready = 1'b1;
        q64.push_back(big);
        for (int i = 0; i < 63; i++) send_bit(1'b1, big[i], 1'b0);
        check("w64_not_yet_valid", 64'(if64.out_valid), 64'd0);
        check("w64_cnt63",         64'(if64.bit_cnt),   64'd63);
        send_bit(1'b1, big[63], 1'b0);
        check("w64_valid", 64'(if64.out_valid), 64'd1);
        check("w64_word",  if64.out_word,       big);
        repeat (3) tick();

        check("q8_drained",  64'(q8.size()),  64'd0);
        check("q64_drained", 64'(q64.size()), 64'd0);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
